// File: rtl/apb_pkg.sv
// Shared constants for the APB timer slave: register offsets, CTRL bit positions
// and transfer FSM encoding.
package apb_pkg;

  localparam logic [7:0] OFF_CTRL  = 8'h00;
  localparam logic [7:0] OFF_LOAD  = 8'h04;
  localparam logic [7:0] OFF_VALUE = 8'h08;
  localparam logic [7:0] OFF_STAT  = 8'h0C;
  localparam logic [7:0] OFF_PRESC = 8'h10;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

endpackage

// File: rtl/apb_timer_core.sv
// Prescaled 32-bit down-counter with one-shot/periodic reload and a sticky FLAG.
module apb_timer_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        periodic,
  input  logic [31:0] load,
  input  logic        value_wr,
  input  logic [31:0] value_wdata,
  input  logic [7:0]  presc,
  input  logic        flag_clr,
  output logic [31:0] value,
  output logic        flag,
  output logic        en_clr
);

  logic [7:0] presc_cnt;
  logic       tick;
  logic       expire;

  assign tick   = en && (presc_cnt == presc);
  assign expire = tick && (value == 32'd0);
  assign en_clr = expire && !periodic;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= 8'd0;
    end else if (!en || tick) begin
      presc_cnt <= 8'd0;
    end else begin
      presc_cnt <= presc_cnt + 8'd1;
    end
  end

  // A bus write to VALUE overrides whatever the tick would have done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 32'd0;
    end else if (value_wr) begin
      value <= value_wdata;
    end else if (tick) begin
      if (value != 32'd0) begin
        value <= value - 32'd1;
      end else if (periodic) begin
        value <= load;
      end
    end
  end

  // Hardware set has priority over a W1C in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (expire) begin
      flag <= 1'b1;
    end else if (flag_clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/apb_timer_slave.sv
// APB responder with wait states, register file and timer; optional error response
// for unmapped offsets is enabled by defining APB_TIMER_PSLVERR_EN.
module apb_timer_slave
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 10
) (
  input  logic              pclk,
  input  logic              hresetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq
);

  logic [0:0]        state;
  logic [1:0]        wait_cnt;
  logic              xfer_done;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr_al;
  logic              sel_ctrl, sel_load, sel_value, sel_stat, sel_presc, mapped;
  logic              ctrl_en, ctrl_periodic, ctrl_ie;
  logic [31:0]       load_reg;
  logic [7:0]        presc_reg;
  logic [31:0]       value;
  logic              flag;
  logic              en_clr;
  logic [31:0]       rdata_mux;
  logic              unused_bits;

  // Transfer FSM: setup moves to ACCESS; completion or a dropped psel returns to IDLE.
  always_ff @(posedge pclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel && !penable) begin
            state    <= ST_ACCESS;
            wait_cnt <= 2'd0;
          end
        end
        ST_ACCESS: begin
          if (!psel || pready) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pready    = (state == ST_ACCESS) && (wait_cnt == 2'(WAIT_STATES));
  assign xfer_done = (state == ST_ACCESS) && psel && penable && pready;
  assign wr_en     = xfer_done && pwrite;
  assign rd_en     = xfer_done && !pwrite;

  assign addr_al   = {paddr[ADDR_W-1:2], 2'b00};
  assign sel_ctrl  = (addr_al == ADDR_W'(OFF_CTRL));
  assign sel_load  = (addr_al == ADDR_W'(OFF_LOAD));
  assign sel_value = (addr_al == ADDR_W'(OFF_VALUE));
  assign sel_stat  = (addr_al == ADDR_W'(OFF_STAT));
  assign sel_presc = (addr_al == ADDR_W'(OFF_PRESC));
  assign mapped    = sel_ctrl || sel_load || sel_value || sel_stat || sel_presc;

  // A CTRL write wins over the one-shot EN auto-clear.
  always_ff @(posedge pclk or negedge hresetn) begin
    if (!hresetn) begin
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_ie       <= 1'b0;
      load_reg      <= 32'd0;
      presc_reg     <= 8'd0;
    end else begin
      if (wr_en && sel_ctrl) begin
        ctrl_en       <= pwdata[CTRL_EN];
        ctrl_periodic <= pwdata[CTRL_PERIODIC];
        ctrl_ie       <= pwdata[CTRL_IE];
      end else if (en_clr) begin
        ctrl_en <= 1'b0;
      end
      if (wr_en && sel_load) begin
        load_reg <= pwdata;
      end
      if (wr_en && sel_presc) begin
        presc_reg <= pwdata[7:0];
      end
    end
  end

  apb_timer_core u_core (
    .clk         (pclk),
    .rst_n       (hresetn),
    .en          (ctrl_en),
    .periodic    (ctrl_periodic),
    .load        (load_reg),
    .value_wr    (wr_en && sel_value),
    .value_wdata (pwdata),
    .presc       (presc_reg),
    .flag_clr    (wr_en && sel_stat && pwdata[0]),
    .value       (value),
    .flag        (flag),
    .en_clr      (en_clr)
  );

  always_comb begin
    rdata_mux = 32'd0;
    if (sel_ctrl)  rdata_mux = {29'd0, ctrl_ie, ctrl_periodic, ctrl_en};
    if (sel_load)  rdata_mux = load_reg;
    if (sel_value) rdata_mux = value;
    if (sel_stat)  rdata_mux = {31'd0, flag};
    if (sel_presc) rdata_mux = {24'd0, presc_reg};
  end

  assign prdata = rd_en ? rdata_mux : 32'd0;
  assign irq    = flag & ctrl_ie;

`ifdef APB_TIMER_PSLVERR_EN
  assign pslverr = xfer_done && !mapped;
`else
  assign pslverr = 1'b0;
`endif

  assign unused_bits = ^{paddr[1:0], mapped};

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench: dut0 has no wait states, dut2 has two; both share clock and reset.
module tb_apb_timer_slave;

  logic        pclk;
  logic        hresetn;
  logic        psel_v    [2];
  logic        penable_v [2];
  logic        pwrite_v  [2];
  logic [9:0]  paddr_v   [2];
  logic [31:0] pwdata_v  [2];
  logic [31:0] prdata_v  [2];
  logic        pready_v  [2];
  logic        pslverr_v [2];
  logic        irq_v     [2];

  int checks = 0;
  int errors = 0;
  logic exp_err;

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  apb_timer_slave #(.WAIT_STATES(0), .ADDR_W(10)) dut0 (
    .pclk(pclk), .hresetn(hresetn), .psel(psel_v[0]), .penable(penable_v[0]),
    .pwrite(pwrite_v[0]), .paddr(paddr_v[0]), .pwdata(pwdata_v[0]),
    .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]), .irq(irq_v[0])
  );

  apb_timer_slave #(.WAIT_STATES(2), .ADDR_W(10)) dut2 (
    .pclk(pclk), .hresetn(hresetn), .psel(psel_v[1]), .penable(penable_v[1]),
    .pwrite(pwrite_v[1]), .paddr(paddr_v[1]), .pwdata(pwdata_v[1]),
    .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]), .irq(irq_v[1])
  );

  // ---------------- driver tasks ----------------
  // Returns 1ns after the rising edge that ends the completing cycle.
  task automatic apb_xfer(input int w, input logic wr, input logic [9:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output int waits, output logic err);
    logic done;
    @(posedge pclk); #1;
    psel_v[w] = 1'b1; penable_v[w] = 1'b0; pwrite_v[w] = wr;
    paddr_v[w] = addr; pwdata_v[w] = wd;
    @(posedge pclk); #1;
    penable_v[w] = 1'b1;
    waits = 0; rd = 32'd0; err = 1'b0; done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge pclk);
      if (pready_v[w] === 1'b1) begin
        rd = prdata_v[w]; err = pslverr_v[w]; done = 1'b1;
      end else begin
        waits++;
      end
    end
    @(posedge pclk); #1;
    psel_v[w] = 1'b0; penable_v[w] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout dut%0d addr=%h: pready never rose, required within 8 cycles", w, addr);
    end
  endtask

  task automatic apb_write(input int w, input logic [9:0] addr, input logic [31:0] wd);
    logic [31:0] rd; int waits; logic err;
    apb_xfer(w, 1'b1, addr, wd, rd, waits, err);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    hresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      psel_v[i] = 0; penable_v[i] = 0; pwrite_v[i] = 0; paddr_v[i] = '0; pwdata_v[i] = '0;
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checks++;
    if ({prdata_v[0], pready_v[0], pslverr_v[0], irq_v[0]} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got prdata=%h pready=%b pslverr=%b irq=%b, required all 0",
               prdata_v[0], pready_v[0], pslverr_v[0], irq_v[0]);
    end
    hresetn = 1'b1;
  endtask

  task automatic test_reset_regs();
    logic [31:0] rd; int waits; logic err;
    for (int a = 0; a <= 16; a += 4) begin
      apb_xfer(0, 1'b0, 10'(a), 32'd0, rd, waits, err);
      checks++;
      if (rd !== 32'd0 || waits !== 0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_read off=%0h: got data=%h waits=%0d err=%b, required 0/0/0", a, rd, waits, err);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int waits; logic err;
    apb_xfer(1, 1'b1, 10'h004, 32'h0000_1234, rd, waits, err);
    checks++;
    if (waits !== 2) begin
      errors++;
      $display("FAIL ws2_write_waits: got %0d, required 2", waits);
    end
    apb_xfer(1, 1'b0, 10'h004, 32'd0, rd, waits, err);
    checks++;
    if (waits !== 2 || rd !== 32'h0000_1234) begin
      errors++;
      $display("FAIL ws2_readback: got waits=%0d data=%h, required 2 / 00001234", waits, rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int waits; logic err;
    @(posedge pclk); #1;
    psel_v[1] = 1; penable_v[1] = 0; pwrite_v[1] = 1; paddr_v[1] = 10'h004; pwdata_v[1] = 32'hDEAD_BEEF;
    @(posedge pclk); #1;
    penable_v[1] = 1;
    @(negedge pclk);
    checks++;
    if (pready_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait_state: got pready=%b, required 0", pready_v[1]);
    end
    @(posedge pclk); #1;
    psel_v[1] = 0; penable_v[1] = 0;
    @(posedge pclk);
    @(negedge pclk);
    checks++;
    if (dut2.state !== 1'b0 || pready_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got state=%b pready=%b, required 0/0", dut2.state, pready_v[1]);
    end
    apb_xfer(1, 1'b0, 10'h004, 32'd0, rd, waits, err);
    checks++;
    if (rd !== 32'h0000_1234) begin
      errors++;
      $display("FAIL abort_load_kept: got %h, required 00001234", rd);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd; int waits; logic err;
    logic [31:0] exp_val;
    int first_irq;
    apb_write(0, 10'h010, 32'd1);
    apb_write(0, 10'h008, 32'd3);
    apb_write(0, 10'h000, 32'h5);
    first_irq = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge pclk);
      @(negedge pclk);
      exp_val = (n < 2) ? 32'd3 : (n < 4) ? 32'd2 : (n < 6) ? 32'd1 : 32'd0;
      checks++;
      if (dut0.u_core.value !== exp_val) begin
        errors++;
        $display("FAIL oneshot_value n=%0d: got %0d, required %0d", n, dut0.u_core.value, exp_val);
      end
      if (irq_v[0] === 1'b1 && first_irq == 0) first_irq = n;
    end
    checks++;
    if (first_irq !== 8) begin
      errors++;
      $display("FAIL oneshot_irq_edge: got irq at edge E+%0d, required E+8", first_irq);
    end
    apb_xfer(0, 1'b0, 10'h000, 32'd0, rd, waits, err);
    checks++;
    if (rd !== 32'h4) begin
      errors++;
      $display("FAIL oneshot_ctrl: got %h, required 00000004", rd);
    end
    apb_xfer(0, 1'b0, 10'h00C, 32'd0, rd, waits, err);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL oneshot_flag: got %h, required 00000001", rd);
    end
    apb_write(0, 10'h00C, 32'd1);
    checks++;
    if (irq_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_w1c_irq: got %b, required 0", irq_v[0]);
    end
  endtask

  task automatic test_periodic();
    apb_write(0, 10'h010, 32'd0);
    apb_write(0, 10'h004, 32'd2);
    apb_write(0, 10'h008, 32'd0);
    apb_write(0, 10'h000, 32'h7);
    // FLAG sets at E+1, E+4, E+7, E+10; this W1C commits at E+4.
    @(posedge pclk);
    apb_write(0, 10'h00C, 32'd1);
    checks++;
    if (irq_v[0] !== 1'b1 || dut0.u_core.value !== 32'd2) begin
      errors++;
      $display("FAIL periodic_set_beats_clr: got irq=%b value=%0d, required 1/2", irq_v[0], dut0.u_core.value);
    end
    @(posedge pclk);
    apb_write(0, 10'h00C, 32'd1);
    checks++;
    if (irq_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL periodic_clr: got irq=%b, required 0", irq_v[0]);
    end
    @(posedge pclk);
    @(posedge pclk); #1;
    checks++;
    if (irq_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL periodic_reflag: got irq=%b, required 1", irq_v[0]);
    end
    apb_write(0, 10'h000, 32'h0);
    apb_write(0, 10'h00C, 32'd1);
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; int waits; logic err;
    apb_write(0, 10'h020, 32'hFFFF_FFFF);
    apb_xfer(0, 1'b0, 10'h020, 32'd0, rd, waits, err);
    checks++;
    if (rd !== 32'd0 || err !== exp_err) begin
      errors++;
      $display("FAIL unmapped_read: got data=%h err=%b, required 00000000/%b", rd, err, exp_err);
    end
    apb_xfer(0, 1'b0, 10'h004, 32'd0, rd, waits, err);
    checks++;
    if (err !== 1'b0 || rd !== 32'd2) begin
      errors++;
      $display("FAIL mapped_no_err: got data=%h err=%b, required 00000002/0", rd, err);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] rd; int waits; logic err;
    apb_write(0, 10'h008, 32'd100);
    apb_write(0, 10'h000, 32'h1);
    repeat (3) @(posedge pclk);
    #1 hresetn = 1'b0;
    #2;
    checks++;
    if (dut0.u_core.value !== 32'd0 || irq_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcount: got value=%0d irq=%b, required 0/0", dut0.u_core.value, irq_v[0]);
    end
    @(negedge pclk);
    hresetn = 1'b1;
    apb_xfer(0, 1'b0, 10'h000, 32'd0, rd, waits, err);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h, required 00000000", rd);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
`ifdef APB_TIMER_PSLVERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    test_reset();
    test_reset_regs();
    test_wait_states();
    test_abort();
    test_oneshot();
    test_periodic();
    test_unmapped();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
